// File: rtl/slave_in_port_pkg.sv
// Shared types and defaults for the serial bus slave input port.
package slave_in_port_pkg;

  localparam int unsigned ADDR_LEN_DEF = 12;
  localparam int unsigned DATA_LEN_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVE   = 2'd1,
    COMMIT    = 2'd2,
    READ_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_INACTIVE = 2'b00,
    OP_WRITE    = 2'b10,
    OP_READ     = 2'b11
  } op_e;

  function automatic int unsigned max_len(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_in_port_if.sv
// Serial master-to-slave lanes plus the parallel local-memory request side.
interface slave_in_port_if
  import slave_in_port_pkg::*;
#(
  parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
  parameter int unsigned DATA_LEN = DATA_LEN_DEF
);
  logic                selected;
  logic                master_valid;
  logic                write_en;
  logic                read_en;
  logic                rx_address;
  logic                rx_data;
  logic                mem_busy;
  logic                resp_done;
  logic                slave_ready;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [DATA_LEN-1:0] mem_wdata;
  logic                mem_write;
  logic                mem_read;
  logic                rx_done;
  logic                frame_error;

  modport slave (
    input  selected, master_valid, write_en, read_en, rx_address, rx_data,
           mem_busy, resp_done,
    output slave_ready, mem_addr, mem_wdata, mem_write, mem_read, rx_done,
           frame_error
  );

  modport master (
    output selected, master_valid, write_en, read_en, rx_address, rx_data,
           mem_busy, resp_done,
    input  slave_ready, mem_addr, mem_wdata, mem_write, mem_read, rx_done,
           frame_error
  );
endinterface

// File: rtl/slave_in_port_serial_capture.sv
// Bit-indexed capture register: stores din into bit idx when enabled; indices past LEN are dropped.
module serial_capture #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic             din,
  output logic [LEN-1:0]   value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else begin
      for (int unsigned i = 0; i < LEN; i++) begin
        if (en && (idx == IDX_W'(i))) value[i] <= din;
      end
    end
  end

endmodule

// File: rtl/slave_in_port.sv
// Slave input port: accepts an LSB-first serial frame, then issues one write or read
// request to local memory; reads keep the slave busy until the response is sent.
module slave_in_port
  import slave_in_port_pkg::*;
#(
  parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
  parameter int unsigned DATA_LEN = DATA_LEN_DEF
) (
  input logic            clk,
  input logic            reset,
  slave_in_port_if.slave bus
);

  localparam int unsigned N     = max_len(ADDR_LEN, DATA_LEN);
  localparam int unsigned CNT_W = $clog2(N) + 1;

  state_e           state, state_d;
  op_e              op, op_d;
  logic [CNT_W-1:0] count, count_d;
  logic             slave_ready_d, mem_write_d, mem_read_d, rx_done_d, frame_error_d;
  logic             cap_en, cap_clear;
  logic [CNT_W-1:0] cap_idx;
  logic             beat_ok;

  assign beat_ok = bus.master_valid && bus.selected;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      op              <= OP_INACTIVE;
      count           <= '0;
      bus.slave_ready <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.rx_done     <= 1'b0;
      bus.frame_error <= 1'b0;
    end else begin
      state           <= state_d;
      op              <= op_d;
      count           <= count_d;
      bus.slave_ready <= slave_ready_d;
      bus.mem_write   <= mem_write_d;
      bus.mem_read    <= mem_read_d;
      bus.rx_done     <= rx_done_d;
      bus.frame_error <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state;
    op_d          = op;
    count_d       = count;
    slave_ready_d = bus.slave_ready;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    rx_done_d     = 1'b0;
    frame_error_d = 1'b0;
    cap_en        = 1'b0;
    cap_clear     = 1'b0;
    cap_idx       = count;

    case (state)
      IDLE: begin
        slave_ready_d = !bus.mem_busy;
        if (beat_ok && (bus.write_en || bus.read_en) && bus.slave_ready) begin
          op_d          = bus.read_en ? OP_READ : OP_WRITE;
          cap_en        = 1'b1;
          cap_idx       = '0;
          count_d       = CNT_W'(1);
          slave_ready_d = 1'b1;
          state_d       = RECEIVE;
        end
      end

      RECEIVE: begin
        if (beat_ok) begin
          cap_en        = 1'b1;
          slave_ready_d = 1'b1;
          if (count == CNT_W'(N - 1)) begin
            count_d       = '0;
            slave_ready_d = 1'b0;
            state_d       = COMMIT;
          end else begin
            count_d = count + CNT_W'(1);
          end
        end else begin
          // Frame broken mid-way: report it, leave captured lanes as they are.
          frame_error_d = 1'b1;
          count_d       = '0;
          slave_ready_d = 1'b0;
          state_d       = IDLE;
        end
      end

      COMMIT: begin
        slave_ready_d = 1'b0;
        if (!bus.mem_busy) begin
          rx_done_d = 1'b1;
          if (op == OP_READ) begin
            mem_read_d = 1'b1;
            state_d    = READ_RESP;
          end else begin
            mem_write_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      READ_RESP: begin
        slave_ready_d = 1'b0;
        if (bus.resp_done) state_d = IDLE;
      end

      default: begin
        state_d       = IDLE;
        op_d          = OP_INACTIVE;
        count_d       = '0;
        slave_ready_d = 1'b0;
        cap_clear     = 1'b1;
      end
    endcase
  end

  serial_capture #(.LEN(ADDR_LEN), .IDX_W(CNT_W)) u_addr_cap (
    .clk   (clk),
    .reset (reset),
    .clear (cap_clear),
    .en    (cap_en),
    .idx   (cap_idx),
    .din   (bus.rx_address),
    .value (bus.mem_addr)
  );

  serial_capture #(.LEN(DATA_LEN), .IDX_W(CNT_W)) u_data_cap (
    .clk   (clk),
    .reset (reset),
    .clear (cap_clear),
    .en    (cap_en),
    .idx   (cap_idx),
    .din   (bus.rx_data),
    .value (bus.mem_wdata)
  );

endmodule

// File: tb/tb_slave_in_port.sv
// Self-checking bench for slave_in_port: idle vector table, directed corner sequences,
// and random frames predicted at the frame level.
module tb_slave_in_port;

  localparam int unsigned AL = 12;
  localparam int unsigned DL = 8;
  localparam int unsigned N  = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  slave_in_port_if #(.ADDR_LEN(AL), .DATA_LEN(DL)) bus ();

  slave_in_port #(.ADDR_LEN(AL), .DATA_LEN(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Expected contents of the address/data lanes as seen by the memory.
  logic [AL-1:0] m_addr = '0;
  logic [DL-1:0] m_data = '0;

  typedef struct {
    logic sel;
    logic valid;
    logic we;
    logic re;
    logic busy;
    logic exp_ready;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.selected     = 1'b0;
    bus.master_valid = 1'b0;
    bus.write_en     = 1'b0;
    bus.read_en      = 1'b0;
    bus.rx_address   = 1'b0;
    bus.rx_data      = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.resp_done    = 1'b0;
  endtask

  function automatic logic [3:0] strobes();
    return {bus.mem_write, bus.mem_read, bus.rx_done, bus.frame_error};
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.slave_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.slave_ready), 32'd1);
  endtask

  task automatic drive_beat(input int i, input logic [AL-1:0] addr, input logic [DL-1:0] data,
                            input bit is_read);
    bus.selected     = 1'b1;
    bus.master_valid = 1'b1;
    if (i == 0) begin
      bus.read_en  = is_read;
      bus.write_en = is_read ? 1'($urandom) : 1'b1;
      bus.mem_busy = 1'b0;
    end else begin
      bus.read_en  = 1'($urandom);
      bus.write_en = 1'($urandom);
      bus.mem_busy = 1'($urandom);
    end
    bus.rx_address = (i < int'(AL)) ? addr[i] : 1'($urandom);
    bus.rx_data    = (i < int'(DL)) ? data[i] : 1'($urandom);
    if (i < int'(AL)) m_addr[i] = addr[i];
    if (i < int'(DL)) m_data[i] = data[i];
  endtask

  // One frame from IDLE with slave_ready=1 back to IDLE with slave_ready=1.
  task automatic run_frame(input logic [AL-1:0] addr, input logic [DL-1:0] data, input bit is_read,
                           input int abort_at, input int busy, input int resp_delay,
                           input bit drop_sel);
    for (int i = 0; i < int'(N); i++) begin
      if (i == abort_at) begin
        bus.selected     = drop_sel ? 1'b0 : 1'b1;
        bus.master_valid = drop_sel ? 1'b1 : 1'b0;
        bus.rx_address   = 1'($urandom);
        bus.rx_data      = 1'($urandom);
        tick();
        chk("abort_error", 32'(bus.frame_error), 32'd1);
        chk("abort_no_strobe", 32'({bus.mem_write, bus.mem_read, bus.rx_done}), 32'd0);
        chk("abort_addr", 32'(bus.mem_addr), 32'(m_addr));
        chk("abort_wdata", 32'(bus.mem_wdata), 32'(m_data));
        idle_inputs();
        tick();
        chk("abort_single_pulse", 32'(strobes()), 32'd0);
        wait_ready("abort_ready");
        return;
      end
      drive_beat(i, addr, data, is_read);
      tick();
      chk("beat_ready", 32'(bus.slave_ready), (i == int'(N) - 1) ? 32'd0 : 32'd1);
      chk("beat_no_strobe", 32'(strobes()), 32'd0);
    end
    idle_inputs();
    bus.mem_busy = (busy > 0);
    for (int b = 0; b < busy; b++) begin
      tick();
      chk("busy_no_strobe", 32'(strobes()), 32'd0);
      chk("busy_ready", 32'(bus.slave_ready), 32'd0);
    end
    bus.mem_busy = 1'b0;
    tick();
    chk("strobe", 32'(strobes()), is_read ? 32'b0110 : 32'b1010);
    chk("strobe_addr", 32'(bus.mem_addr), 32'(m_addr));
    chk("strobe_wdata", 32'(bus.mem_wdata), 32'(m_data));
    chk("strobe_ready", 32'(bus.slave_ready), 32'd0);
    tick();
    chk("strobe_once", 32'(strobes()), 32'd0);
    chk("addr_hold", 32'(bus.mem_addr), 32'(m_addr));
    if (!is_read) begin
      chk("ready_after_write", 32'(bus.slave_ready), 32'd1);
    end else begin
      for (int d = 0; d < resp_delay; d++) begin
        chk("resp_wait_ready", 32'(bus.slave_ready), 32'd0);
        tick();
      end
      bus.resp_done = 1'b1;
      tick();
      bus.resp_done = 1'b0;
      chk("ready_at_resp", 32'(bus.slave_ready), 32'd0);
      tick();
      chk("ready_after_resp", 32'(bus.slave_ready), 32'd1);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("reset_outputs", 32'({strobes(), bus.slave_ready}), 32'd0);
    chk("reset_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset_wdata", 32'(bus.mem_wdata), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("idle_ready", 32'(bus.slave_ready), 32'd1);

    // IDLE vectors: none of these may start a frame.
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 7; v++) begin
      bus.selected     = vecs[v].sel;
      bus.master_valid = vecs[v].valid;
      bus.write_en     = vecs[v].we;
      bus.read_en      = vecs[v].re;
      bus.mem_busy     = vecs[v].busy;
      bus.rx_address   = 1'b1;
      bus.rx_data      = 1'b1;
      tick();
      chk($sformatf("vec%0d_ready", v), 32'(bus.slave_ready), 32'(vecs[v].exp_ready));
      chk($sformatf("vec%0d_strobes", v), 32'(strobes()), 32'd0);
      chk($sformatf("vec%0d_addr", v), 32'(bus.mem_addr), 32'(m_addr));
    end
    idle_inputs();
    wait_ready("table_ready");

    // Directed sequences.
    run_frame(12'hA5C, 8'h3B, 1'b0, N, 0, 0, 1'b0);
    run_frame(12'h001, m_data, 1'b1, N, 0, 5, 1'b0);
    run_frame(12'h6D2, 8'hC4, 1'b0, 7, 0, 0, 1'b0);
    run_frame(12'h3E7, 8'h91, 1'b0, N, 3, 0, 1'b0);
    run_frame(12'h155, 8'h2A, 1'b0, 5, 0, 0, 1'b1);

    // Reset in the middle of a frame.
    for (int i = 0; i < 4; i++) begin
      drive_beat(i, 12'h5A5, 8'h5A, 1'b0);
      tick();
    end
    drive_beat(4, 12'h5A5, 8'h5A, 1'b0);
    reset = 1'b0;
    #1;
    m_addr = '0;
    m_data = '0;
    chk("midreset_outputs", 32'({strobes(), bus.slave_ready}), 32'd0);
    chk("midreset_addr", 32'(bus.mem_addr), 32'd0);
    chk("midreset_wdata", 32'(bus.mem_wdata), 32'd0);
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
    wait_ready("post_reset_ready");
    run_frame(12'hFFF, 8'hFF, 1'b0, N, 0, 0, 1'b0);

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      logic [AL-1:0] a;
      logic [DL-1:0] d;
      int ab;
      a  = AL'($urandom);
      d  = DL'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : int'(N);
      run_frame(a, d, 1'($urandom), ab, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule
